// File: rtl/branch_pkg.sv
// Shared decode constants, FSM states and branch kinds for the branch sequencer.
package branch_pkg;

   localparam logic [5:0] OPC_B    = 6'd18;
   localparam logic [5:0] OPC_BC   = 6'd16;
   localparam logic [5:0] OPC_XL   = 6'd19;
   localparam logic [9:0] XO_BCLR  = 10'd16;
   localparam logic [9:0] XO_BCCTR = 10'd528;

   typedef enum logic [1:0] {IDLE, EVAL, WB, REDIR} state_t;

   typedef enum logic [2:0] {B, BC, BCLR, BCCTR, ILLEGAL} kind_t;

endpackage

// File: rtl/branch_eval.sv
// Combinational branch evaluation: decode, CTR update, condition test and next-address select.
module branch_eval
   import branch_pkg::*;
(
   input  logic [63:0] cia_i,
   input  logic [31:0] instr_i,
   input  logic        mode32_i,
   input  logic [31:0] cr_i,
   input  logic [63:0] lr_i,
   input  logic [63:0] ctr_i,
   output kind_t       kind_o,
   output logic        taken_o,
   output logic        illegal_o,
   output logic [63:0] ctr_next_o,
   output logic [63:0] nia_o,
   output logic [63:0] link_o,
   output logic        lr_we_o
);

   logic [4:0]  bo;
   logic [4:0]  bi;
   logic [63:0] cia4;
   logic [63:0] target;
   logic [63:0] nia_raw;
   logic        dec;
   logic        ctr_nz;
   logic        ctr_ok;
   logic        cond_ok;

   always_comb begin
      // instr bit 31 is ISA bit 0, so BO0 is bo[4] and BO3 is bo[1]
      bo = instr_i[25:21];
      bi = instr_i[20:16];

      kind_o = ILLEGAL;
      if (instr_i[31:26] == OPC_B)
         kind_o = B;
      else if (instr_i[31:26] == OPC_BC)
         kind_o = BC;
      else if (instr_i[31:26] == OPC_XL && instr_i[10:1] == XO_BCLR)
         kind_o = BCLR;
      else if (instr_i[31:26] == OPC_XL && instr_i[10:1] == XO_BCCTR)
         kind_o = BCCTR;

      dec        = ~bo[2] & (kind_o == BC || kind_o == BCLR);
      ctr_next_o = dec ? ctr_i - 64'd1 : ctr_i;
      ctr_nz     = mode32_i ? (ctr_next_o[31:0] != '0) : (ctr_next_o != '0);
      ctr_ok     = bo[2] | (ctr_nz ^ bo[1]);
      cond_ok    = bo[4] | (cr_i[5'd31 - bi] == bo[3]);
      illegal_o  = (kind_o == ILLEGAL) || (kind_o == BCCTR && !bo[2]);

      cia4 = cia_i + 64'd4;
      case (kind_o)
         B:       target = {{38{instr_i[25]}}, instr_i[25:2], 2'b00} + (instr_i[1] ? 64'd0 : cia_i);
         BC:      target = {{48{instr_i[15]}}, instr_i[15:2], 2'b00} + (instr_i[1] ? 64'd0 : cia_i);
         BCLR:    target = lr_i & ~64'h3;
         default: target = ctr_i & ~64'h3;
      endcase

      taken_o = !illegal_o && (kind_o == B || (ctr_ok && cond_ok));
      nia_raw = taken_o ? target : cia4;
      nia_o   = mode32_i ? {32'h0, nia_raw[31:0]} : nia_raw;
      link_o  = mode32_i ? {32'h0, cia4[31:0]} : cia4;
      lr_we_o = instr_i[0] & ~illegal_o;
   end

endmodule

// File: rtl/branch_sequencer.sv
// Branch request sequencer: latches a request, evaluates it, pulses LR/CTR writes, then redirects.
module branch_sequencer
   import branch_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [63:0] i_cia,
   input  logic [31:0] i_instr,
   input  logic        i_32b_mode,
   input  logic [31:0] i_cr,
   input  logic [63:0] i_lr,
   input  logic [63:0] i_ctr,
   output logic        o_lr_we,
   output logic [63:0] o_lr_wdata,
   output logic        o_ctr_we,
   output logic [63:0] o_ctr_wdata,
   output logic        o_redir_valid,
   input  logic        i_redir_ready,
   output logic [63:0] o_nia,
   output logic        o_taken,
   output logic        o_illegal
);

   state_t      state_q;
   logic [63:0] cia_q, lr_q, ctr_q;
   logic [31:0] instr_q, cr_q;
   logic        mode_q;

   logic        req_ready_q, lr_we_q, ctr_we_q, redir_valid_q, taken_q, illegal_q;
   logic [63:0] lr_wdata_q, ctr_wdata_q, nia_q;

   kind_t       kind_d;
   logic        taken_d, illegal_d, lr_we_d, ctr_we_d;
   logic [63:0] ctr_next_d, nia_d, link_d;

   branch_eval u_eval (
      .cia_i      (cia_q),
      .instr_i    (instr_q),
      .mode32_i   (mode_q),
      .cr_i       (cr_q),
      .lr_i       (lr_q),
      .ctr_i      (ctr_q),
      .kind_o     (kind_d),
      .taken_o    (taken_d),
      .illegal_o  (illegal_d),
      .ctr_next_o (ctr_next_d),
      .nia_o      (nia_d),
      .link_o     (link_d),
      .lr_we_o    (lr_we_d)
   );

   always_comb ctr_we_d = (kind_d == BC || kind_d == BCLR) && !instr_q[23];

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q       <= IDLE;
         req_ready_q   <= 1'b1;
         lr_we_q       <= 1'b0;
         ctr_we_q      <= 1'b0;
         redir_valid_q <= 1'b0;
         taken_q       <= 1'b0;
         illegal_q     <= 1'b0;
         lr_wdata_q    <= '0;
         ctr_wdata_q   <= '0;
         nia_q         <= '0;
         cia_q         <= '0;
         lr_q          <= '0;
         ctr_q         <= '0;
         instr_q       <= '0;
         cr_q          <= '0;
         mode_q        <= 1'b0;
      end else begin
         lr_we_q  <= 1'b0;
         ctr_we_q <= 1'b0;
         case (state_q)
            IDLE: if (i_req_valid) begin
               cia_q       <= i_cia;
               instr_q     <= i_instr;
               mode_q      <= i_32b_mode;
               cr_q        <= i_cr;
               lr_q        <= i_lr;
               ctr_q       <= i_ctr;
               req_ready_q <= 1'b0;
               state_q     <= EVAL;
            end
            EVAL: begin
               nia_q       <= nia_d;
               taken_q     <= taken_d;
               illegal_q   <= illegal_d;
               lr_we_q     <= lr_we_d;
               lr_wdata_q  <= link_d;
               ctr_we_q    <= ctr_we_d;
               ctr_wdata_q <= ctr_next_d;
               state_q     <= WB;
            end
            WB: begin
               redir_valid_q <= 1'b1;
               state_q       <= REDIR;
            end
            REDIR: if (i_redir_ready) begin
               redir_valid_q <= 1'b0;
               req_ready_q   <= 1'b1;
               state_q       <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_req_ready   = req_ready_q;
   assign o_lr_we       = lr_we_q;
   assign o_lr_wdata    = lr_wdata_q;
   assign o_ctr_we      = ctr_we_q;
   assign o_ctr_wdata   = ctr_wdata_q;
   assign o_redir_valid = redir_valid_q;
   assign o_nia         = nia_q;
   assign o_taken       = taken_q;
   assign o_illegal     = illegal_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer with a queue of expected redirects and write pulses.
module tb_branch_sequencer;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [63:0] i_cia;
   logic [31:0] i_instr;
   logic        i_32b_mode;
   logic [31:0] i_cr;
   logic [63:0] i_lr;
   logic [63:0] i_ctr;
   logic        o_lr_we;
   logic [63:0] o_lr_wdata;
   logic        o_ctr_we;
   logic [63:0] o_ctr_wdata;
   logic        o_redir_valid;
   logic        i_redir_ready;
   logic [63:0] o_nia;
   logic        o_taken;
   logic        o_illegal;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   typedef struct packed {
      logic [63:0] nia;
      logic        taken;
      logic        illegal;
      logic        lr_we;
      logic [63:0] lr_wd;
      logic        ctr_we;
      logic [63:0] ctr_wd;
   } exp_t;

   exp_t sb[$];

   branch_sequencer dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_req_valid   (i_req_valid),
      .o_req_ready   (o_req_ready),
      .i_cia         (i_cia),
      .i_instr       (i_instr),
      .i_32b_mode    (i_32b_mode),
      .i_cr          (i_cr),
      .i_lr          (i_lr),
      .i_ctr         (i_ctr),
      .o_lr_we       (o_lr_we),
      .o_lr_wdata    (o_lr_wdata),
      .o_ctr_we      (o_ctr_we),
      .o_ctr_wdata   (o_ctr_wdata),
      .o_redir_valid (o_redir_valid),
      .i_redir_ready (i_redir_ready),
      .o_nia         (o_nia),
      .o_taken       (o_taken),
      .o_illegal     (o_illegal)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] nia, input logic taken, input logic illegal,
                               input logic lr_we, input logic [63:0] lr_wd,
                               input logic ctr_we, input logic [63:0] ctr_wd);
      exp_t e;
      e.nia = nia; e.taken = taken; e.illegal = illegal;
      e.lr_we = lr_we; e.lr_wd = lr_wd; e.ctr_we = ctr_we; e.ctr_wd = ctr_wd;
      return e;
   endfunction

   task automatic run_branch(input string tag, input logic [63:0] cia, input logic [31:0] instr,
                             input logic m32, input logic [31:0] cr, input logic [63:0] lr,
                             input logic [63:0] ctr, input exp_t e, input int unsigned hold);
      exp_t got;
      int unsigned w;
      w = 0;
      while (o_req_ready !== 1'b1 && w < 16) begin
         step();
         w++;
      end
      check({tag, " req_ready"}, o_req_ready, 64'd1);
      i_cia = cia; i_instr = instr; i_32b_mode = m32; i_cr = cr; i_lr = lr; i_ctr = ctr;
      i_req_valid = 1'b1;
      sb.push_back(e);
      step();
      // inputs scrambled after accept must not disturb the latched request
      i_req_valid = 1'b0;
      i_cia = ~cia; i_instr = $urandom(); i_32b_mode = ~m32; i_cr = ~cr; i_lr = ~lr; i_ctr = ~ctr;
      check({tag, " eval lr_we"}, o_lr_we, 64'd0);
      check({tag, " eval ctr_we"}, o_ctr_we, 64'd0);
      check({tag, " eval redir"}, o_redir_valid, 64'd0);
      check({tag, " eval ready"}, o_req_ready, 64'd0);
      step();
      check({tag, " wb lr_we"}, o_lr_we, e.lr_we);
      check({tag, " wb ctr_we"}, o_ctr_we, e.ctr_we);
      check({tag, " wb redir"}, o_redir_valid, 64'd0);
      if (e.lr_we) check({tag, " wb lr_wdata"}, o_lr_wdata, e.lr_wd);
      if (e.ctr_we) check({tag, " wb ctr_wdata"}, o_ctr_wdata, e.ctr_wd);
      step();
      check({tag, " redir valid"}, o_redir_valid, 64'd1);
      check({tag, " redir lr_we"}, o_lr_we, 64'd0);
      check({tag, " redir ctr_we"}, o_ctr_we, 64'd0);
      check({tag, " redir ready"}, o_req_ready, 64'd0);
      got = sb.pop_front();
      for (int unsigned h = 0; h <= hold; h++) begin
         check({tag, " nia"}, o_nia, got.nia);
         check({tag, " taken"}, o_taken, got.taken);
         check({tag, " illegal"}, o_illegal, got.illegal);
         check({tag, " held valid"}, o_redir_valid, 64'd1);
         if (h < hold) step();
      end
      i_redir_ready = 1'b1;
      step();
      i_redir_ready = 1'b0;
      check({tag, " ret valid"}, o_redir_valid, 64'd0);
      check({tag, " ret ready"}, o_req_ready, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      i_rst = 1'b0; i_req_valid = 1'b0; i_redir_ready = 1'b0;
      i_cia = '0; i_instr = '0; i_32b_mode = 1'b0; i_cr = '0; i_lr = '0; i_ctr = '0;
      step();
      step();
      check("rst req_ready", o_req_ready, 64'd1);
      check("rst redir", o_redir_valid, 64'd0);
      check("rst lr_we", o_lr_we, 64'd0);
      check("rst ctr_we", o_ctr_we, 64'd0);
      check("rst nia", o_nia, 64'd0);
      check("rst taken", o_taken, 64'd0);
      check("rst illegal", o_illegal, 64'd0);
      check("rst lr_wdata", o_lr_wdata, 64'd0);
      check("rst ctr_wdata", o_ctr_wdata, 64'd0);
      i_rst = 1'b1;
      step();

      run_branch("b_rel_lk", 64'h1000, 32'h4800_0021, 1'b0, 32'h0, 64'h0, 64'h77,
                 mk(64'h1020, 1'b1, 1'b0, 1'b1, 64'h1004, 1'b0, 64'h0), 0);
      run_branch("bdnz_ctr1", 64'h3000, 32'h4200_0040, 1'b0, 32'h0, 64'h0, 64'h1,
                 mk(64'h3004, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h0), 0);
      run_branch("bdnz_ctr5", 64'h3000, 32'h4200_0040, 1'b0, 32'h0, 64'h0, 64'h5,
                 mk(64'h3040, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 64'h4), 0);
      run_branch("bclrl", 64'h500, 32'h4E80_0021, 1'b0, 32'h0, 64'h2000, 64'h9,
                 mk(64'h2000, 1'b1, 1'b0, 1'b1, 64'h504, 1'b0, 64'h0), 0);
      run_branch("bcctr_dec_ill", 64'h700, 32'h4E00_0421, 1'b0, 32'h0, 64'h0, 64'h40,
                 mk(64'h704, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0), 5);
      run_branch("b32_wrap", 64'hFFFF_FFFC, 32'h4800_0004, 1'b1, 32'h0, 64'h0, 64'h0,
                 mk(64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0), 0);
      run_branch("bc_cr_true", 64'h4000, 32'h4182_FFF8, 1'b0, 32'h2000_0000, 64'h0, 64'h3,
                 mk(64'h3FF8, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0), 0);
      run_branch("bc_cr_false", 64'h4000, 32'h4182_FFF8, 1'b0, 32'hDFFF_FFFF, 64'h0, 64'h3,
                 mk(64'h4004, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0), 0);
      run_branch("bad_opcode", 64'h800, 32'h0000_0000, 1'b0, 32'h0, 64'h0, 64'h0,
                 mk(64'h804, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0), 1);
      run_branch("bcctr", 64'h900, 32'h4E80_0420, 1'b0, 32'h0, 64'h0, 64'h1237,
                 mk(64'h1234, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0), 0);
      run_branch("b_abs", 64'h9000, 32'h4800_0102, 1'b0, 32'h0, 64'h0, 64'h0,
                 mk(64'h100, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0), 0);
      run_branch("bdnz32", 64'h6000, 32'h4200_0040, 1'b1, 32'h0, 64'h0, 64'h1_0000_0001,
                 mk(64'h6004, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h1_0000_0000), 0);

      // reset while the WB pulse is showing abandons the request
      i_cia = 64'h1000; i_instr = 32'h4200_0041; i_32b_mode = 1'b0; i_ctr = 64'h5;
      i_req_valid = 1'b1;
      step();
      i_req_valid = 1'b0;
      step();
      check("rstwb in_wb lr_we", o_lr_we, 64'd1);
      i_rst = 1'b0;
      step();
      i_rst = 1'b1;
      check("rstwb lr_we", o_lr_we, 64'd0);
      check("rstwb ctr_we", o_ctr_we, 64'd0);
      check("rstwb redir", o_redir_valid, 64'd0);
      check("rstwb ready", o_req_ready, 64'd1);
      for (int k = 0; k < 4; k++) begin
         step();
         check("rstwb after redir", o_redir_valid, 64'd0);
         check("rstwb after lr_we", o_lr_we, 64'd0);
         check("rstwb after ctr_we", o_ctr_we, 64'd0);
      end

      run_branch("post_rst_b", 64'h1000, 32'h4800_0021, 1'b0, 32'h0, 64'h0, 64'h0,
                 mk(64'h1020, 1'b1, 1'b0, 1'b1, 64'h1004, 1'b0, 64'h0), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
